// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies with a shift-add accumulator and divides with a restoring loop,
// both on operand magnitudes, then applies the sign in a final FIX cycle.
// Divide-by-zero and signed overflow finish in one cycle without the loop.
// Handshake: start is accepted only on an edge where busy=0 and kill=0;
// done is a one-cycle pulse in the cycle after result is written, and
// result holds its value until the next done.
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state_o
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             sa_q, sb_q;
    logic [WIDTH-1:0] hi_q, lo_q, mb_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    // Input decode: signedness, magnitudes and one-cycle divide cases.
    logic             signed_a, signed_b, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;
    logic             special;

    // Decode operands presented with start.
    always_comb begin
        signed_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        signed_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        neg_a    = signed_a && a[WIDTH-1];
        neg_b    = signed_b && b[WIDTH-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
        special  = op[2] && ((b == '0) ||
                   (!op[0] && (a == INT_MIN) && (b == ONES)));
        // op[1] separates REM/REMU from DIV/DIVU.
        if (b == '0) special_res = op[1] ? a : ONES;
        else         special_res = op[1] ? '0 : a;
    end

    // One CALC step: UNROLL bits of shift-add or restoring division.
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   sum, rem_t;

    always_comb begin
        hi_n  = hi_q;
        lo_n  = lo_q;
        sum   = '0;
        rem_t = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (!op_q[2]) begin
                // hi accumulates the partial product, lo shifts out the multiplier.
                sum = {1'b0, hi_n} + (lo_n[0] ? {1'b0, mb_q} : '0);
                {hi_n, lo_n} = {sum, lo_n[WIDTH-1:1]};
            end else begin
                // hi is the partial remainder, lo shifts dividend out / quotient in.
                rem_t = {hi_n, lo_n[WIDTH-1]};
                lo_n  = {lo_n[WIDTH-2:0], 1'b0};
                if (rem_t >= {1'b0, mb_q}) begin
                    rem_t   = rem_t - {1'b0, mb_q};
                    lo_n[0] = 1'b1;
                end
                hi_n = rem_t[WIDTH-1:0];
            end
        end
    end

    // FIX: sign correction and output selection.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_s  = sa_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:                fix_res = prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          fix_res = quo_s;
            default:             fix_res = rem_s;
        endcase
    end

    // Control FSM and datapath registers; kill overrides everything but rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mb_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (kill) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        sa_q <= neg_a;
                        sb_q <= neg_b;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= mag_a;
                            mb_q    <= mag_b;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one UNROLL=1 and one UNROLL=4 instance.
// Drivers push {expected done cycle, expected result} into a queue per unit;
// a monitor per unit pops and compares whenever done is seen.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, kill1, start4, kill4;
    logic [2:0]  op1, op4;
    logic [31:0] a1, b1, a4, b4;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;
    logic [1:0]  st1, st4;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [31:0] last1 = '0;

    logic [63:0] exp_q1[$];
    logic [63:0] exp_q4[$];

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .kill(kill1), .op(op1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .result(result1),
        .dbg_state_o(st1)
    );

    muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .kill(kill4), .op(op4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .result(result4),
        .dbg_state_o(st4)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // watchdog
    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Reference model built on 64-bit language arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ps;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin ps = sa * sb; p = ps; return p[63:32]; end
            3'd2: begin ps = sa * longint'(ub); p = ps; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                ps = sa / sb; p = ps; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                ps = sa % sb; p = ps; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Driver: wait for idle, issue one op, push its expectation.
    task automatic run(input bit u4, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int lat, guard;
        bit sp;
        sp  = is_special(op, a, b);
        lat = sp ? 1 : (u4 ? 10 : 34);
        guard = 0;
        @(negedge clk);
        while ((u4 ? busy4 : busy1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            chk_cnt++;
            $display("FAIL idle_wait: unit still busy after %0d cycles", guard);
        end
        if (u4) begin
            start4 = 1'b1; op4 = op; a4 = a; b4 = b;
            exp_q4.push_back({32'(cyc + lat), exp});
        end else begin
            start1 = 1'b1; op1 = op; a1 = a; b1 = b;
            exp_q1.push_back({32'(cyc + lat), exp});
            last1 = exp;
        end
        @(negedge clk);
        if (u4) begin
            start4 = 1'b0;
            check("busy_after_accept4", {63'b0, busy4}, {63'b0, !sp});
        end else begin
            start1 = 1'b0;
            check("busy_after_accept1", {63'b0, busy1}, {63'b0, !sp});
        end
    endtask

    task automatic wait_empty();
        int guard = 0;
        while ((exp_q1.size() != 0 || exp_q4.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            chk_cnt++;
            $display("FAIL drain: %0d/%0d responses outstanding", exp_q1.size(), exp_q4.size());
        end
    endtask

    // Monitor for the UNROLL=1 unit.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && done1) begin
            if (exp_q1.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_done1: done with result %h and nothing expected", result1);
            end else begin
                e = exp_q1.pop_front();
                check("done_cycle1", 64'(cyc), {32'b0, e[63:32]});
                check("result1", {32'b0, result1}, {32'b0, e[31:0]});
                check("busy_in_done1", {63'b0, busy1}, 64'd0);
            end
        end
    end

    // Monitor for the UNROLL=4 unit.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && done4) begin
            if (exp_q4.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_done4: done with result %h and nothing expected", result4);
            end else begin
                e = exp_q4.pop_front();
                check("done_cycle4", 64'(cyc), {32'b0, e[63:32]});
                check("result4", {32'b0, result4}, {32'b0, e[31:0]});
                check("busy_in_done4", {63'b0, busy4}, 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] corners [6];
        int c0;
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7};
        rst = 1'b1;
        start1 = 0; kill1 = 0; op1 = 0; a1 = 0; b1 = 0;
        start4 = 0; kill4 = 0; op4 = 0; a4 = 0; b4 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy1",   {63'b0, busy1},   64'd0);
        check("reset_done1",   {63'b0, done1},   64'd0);
        check("reset_result1", {32'b0, result1}, 64'd0);
        check("reset_state1",  {62'b0, st1},     64'd0);
        check("reset_busy4",   {63'b0, busy4},   64'd0);
        check("reset_result4", {32'b0, result4}, 64'd0);

        // Directed vectors, UNROLL=1 (consecutive normal ops are back-to-back).
        run(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run(0, 3'd5, 32'd100,      32'd7,        32'd14);
        run(0, 3'd7, 32'd100,      32'd7,        32'd2);
        run(0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF);
        run(0, 3'd6, 32'd5,        32'd0,        32'd5);
        run(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        wait_empty();

        // Kill a DIV in cycle 10, then start a DIVU in cycle 11.
        @(negedge clk);
        c0 = cyc;
        start1 = 1'b1; op1 = 3'd4; a1 = 32'hFFFFFFF9; b1 = 32'd2;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        kill1 = 1'b1;
        @(negedge clk);
        kill1 = 1'b0;
        check("kill_busy",   {63'b0, busy1},   64'd0);
        check("kill_done",   {63'b0, done1},   64'd0);
        check("kill_result", {32'b0, result1}, {32'b0, last1});
        start1 = 1'b1; op1 = 3'd5; a1 = 32'd100; b1 = 32'd7;
        exp_q1.push_back({32'(c0 + 45), 32'd14});
        last1 = 32'd14;
        @(negedge clk);
        start1 = 1'b0;
        wait_empty();

        // Start together with kill is dropped.
        @(negedge clk);
        start1 = 1'b1; kill1 = 1'b1; op1 = 3'd0; a1 = 32'd2; b1 = 32'd3;
        @(negedge clk);
        start1 = 1'b0; kill1 = 1'b0;
        check("start_with_kill_busy", {63'b0, busy1}, 64'd0);
        repeat (40) @(negedge clk);
        check("start_with_kill_result", {32'b0, result1}, {32'b0, last1});

        // UNROLL=4: MUL, an ignored start during busy, then a back-to-back op.
        run(1, 3'd0, 32'd12345, 32'd6789, 32'd83810205);
        @(negedge clk);
        start4 = 1'b1; op4 = 3'd3; a4 = 32'd3; b4 = 32'd3;
        @(negedge clk);
        start4 = 1'b0;
        run(1, 3'd7, 32'd100, 32'd7, 32'd2);
        run(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        wait_empty();

        // Corner operands over all ops on both units, plus a few random ones.
        fork
            begin
                for (int o = 0; o < 8; o++)
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 6; j++)
                            run(0, 3'(o), corners[i], corners[j], ref_op(3'(o), corners[i], corners[j]));
                for (int r = 0; r < 24; r++) begin
                    logic [2:0]  ro;
                    logic [31:0] ra, rb;
                    ro = 3'($urandom_range(0, 7));
                    ra = $urandom;
                    rb = (r % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                    run(0, ro, ra, rb, ref_op(ro, ra, rb));
                end
            end
            begin
                for (int o = 0; o < 8; o++)
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 6; j++)
                            run(1, 3'(o), corners[j], corners[i], ref_op(3'(o), corners[j], corners[i]));
            end
        join
        wait_empty();

        // Reset in the middle of an operation clears result.
        @(negedge clk);
        start1 = 1'b1; op1 = 3'd0; a1 = 32'd9; b1 = 32'd9;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   {63'b0, busy1},   64'd0);
        check("midrst_done",   {63'b0, done1},   64'd0);
        check("midrst_result", {32'b0, result1}, 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_no_done_result", {32'b0, result1}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit, parametrised in operand width and bits retired per cycle. It attaches to the multicycle core's EX cycle for OP_OP instructions with funct7 = 0000001. The core holds in EX until `done`, then writes `result` to rd. Special divide cases complete in one cycle; everything else runs a shift-add or restoring-divide loop on magnitudes, followed by a sign-fix cycle.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must be even and ≥ 4
- UNROLL, 1, bits processed per CALC cycle; must divide WIDTH; N = WIDTH/UNROLL

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when the unit is idle (busy=0)
- kill  in  1  abort in-flight operation (pipeline flush/trap)
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  WIDTH  rs1 operand, sampled on the accepting edge
- b  in  WIDTH  rs2 operand, sampled on the accepting edge
- busy  out  1  operation in progress (CALC or FIX)
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  registered; holds its value until the next done

## Operation

- States: IDLE, CALC, FIX. Reset: state IDLE, busy=0, done=0, result=0, counter=0.
- IDLE + start (kill=0): latch op, operand magnitudes and sign flags.
  - Signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned. MUL, MULHU, DIVU and REMU are unsigned.
  - Divide special cases bypass the loop: next state IDLE, done=1, result written on the same edge.
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (DIV/REM, a = −2^(WIDTH−1), b = −1): DIV → a; REM → 0.
  - Otherwise: next state CALC, counter=0.
- CALC: each edge processes UNROLL bits and increments the counter. After the N-th CALC edge, next state is FIX.
  - Multiply: 2·WIDTH-bit shift-add accumulator on magnitudes.
  - Divide: restoring division on magnitudes.
- FIX: applies sign correction, selects the output, writes result, sets done=1, then returns to IDLE.
  - Product negated if the sign flags differ.
  - MUL selects the low WIDTH bits; MULH/MULHSU/MULHU select the high WIDTH bits.
  - Quotient sign = sa^sb; remainder sign = sa.
- done is high only in the cycle after the writing edge. `result` never changes except on that edge.
- kill has priority over everything:
  - In any state, the next state is IDLE and done=0.
  - `result` is unchanged.
  - A start asserted in the same cycle as kill is ignored.
- start while busy=1 is ignored; it is neither queued nor reported as an error.
- All arithmetic is modulo 2^WIDTH, except the internal 2·WIDTH-bit product. No X may propagate to outputs after reset.

## Timing

- Accepting edge = end of cycle 0.
- Normal operation:
  - busy=1 in cycles 1..N+1 (CALC 1..N, FIX N+1).
  - done=1 in cycle N+2.
  - Latency N+2 (34 for WIDTH=32, UNROLL=1; 10 for UNROLL=4).
- Special divide case: busy stays 0; done=1 in cycle 1.
- Back-to-back: busy=0 in the done cycle, so a start in that cycle is accepted. The next done follows N+2 cycles later (or 1 cycle for a special case).
- kill in cycle k (k ≤ N+1): busy=0 and done=0 in cycle k+1. A start in cycle k+1 is accepted normally.
- rst mid-operation: identical to the reset values above; `result` is cleared to 0.

## Test plan

- MUL a=7, b=0xFFFFFFFD (−3), start cycle 0 → busy cycles 1–33, done cycle 34, result 0xFFFFFFEB. Repeat with MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF (−1)×0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=−7, b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each has latency 34.
- Special cases, each with done in cycle 1 and busy never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- kill at cycle 10 of a DIV → no done, busy=0 in cycle 11, previous result unchanged. A start in cycle 11 completes correctly in cycle 45. A start asserted with kill is dropped.
- UNROLL=4: MUL 12345×6789 → 83810205, done cycle 10. A start issued during busy is ignored. A start in the done cycle is accepted and finishes 10 cycles later.
- Randomised compare against a reference model over all ops, including −2^31, 0, ±1 and all-ones operands.
